// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: parameter legality helpers
// used at elaboration time by the top level.
package fifo_pkg;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Thresholds must leave a non-empty gap and fit inside the buffer.
  function automatic bit params_legal(input int depth, input int ae, input int af);
    return is_pow2(depth) && (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-address read and write returns the old entry,
  // which is what a full FIFO doing a simultaneous read+write needs.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock circular-buffer FIFO with occupancy count,
// programmable almost flags, read-valid strobe and overflow/underflow pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] AF_C = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_C = (AW + 1)'(AE_THRESH);

  if (!params_legal(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_params
    $error("sync_fifo: illegal DEPTH/AE_THRESH/AF_THRESH combination");
  end

  logic [AW:0]           wp_q, wp_d;
  logic [AW:0]           rp_q, rp_d;
  logic [AW:0]           count_q, count_d;
  logic                  dout_valid_q;
  logic                  dout_loaded_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Wrap bits differ with equal index means the buffer is full.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

  always_comb begin
    rd_ok   = rd_en && !empty;
    wr_ok   = wr_en && (!full || rd_ok);
    wp_d    = wr_ok ? wp_q + 1'b1 : wp_q;
    rp_d    = rd_ok ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      dout_valid_q  <= 1'b0;
      dout_loaded_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      dout_valid_q  <= rd_ok;
      dout_loaded_q <= dout_loaded_q || rd_ok;
      overflow_q    <= wr_en && !wr_ok;
      underflow_q   <= rd_en && !rd_ok;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp_q[AW-1:0]),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rp_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so dout reads as zero until the
  // first accepted read since reset has loaded it.
  assign dout         = dout_loaded_q ? ram_rdata : '0;
  assign dout_valid   = dout_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_dv = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, ":dout_valid"}, 32'(dout_valid), 32'(exp_dv));
    chk({tag, ":overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock cycle of traffic; the model decides acceptance from the
  // occupancy before the edge, exactly as a user of the FIFO would reason.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    bit rd_acc;
    bit wr_acc;
    wr_en = w;
    din   = d;
    rd_en = r;
    rd_acc = r && (model_q.size() > 0);
    wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
    exp_dv = rd_acc;
    if (rd_acc) exp_dout = model_q.pop_front();
    if (wr_acc) model_q.push_back(d);
    exp_ovf = w && !wr_acc;
    exp_unf = r && !rd_acc;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
    $display("step %-8s wr=%0b din=%02h rd=%0b -> count=%0d dout=%02h dv=%0b ovf=%0b unf=%0b",
             tag, w, d, r, count, dout, dout_valid, overflow, underflow);
  endtask

  initial begin
    // Reset state while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Fill, then a rejected 17th write, then an idle cycle to see the pulse end.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    step("ovf", 1'b1, 8'h99, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0);

    // Drain in order, then one rejected read; dout must hold 0x10.
    for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);
    step("unf", 1'b0, 8'h00, 1'b1);
    chk("unf:dout_hold", 32'(dout), 32'h10);

    // Index wrap-around.
    for (int i = 0; i < 10; i++) step("wrap_w1", 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step("wrap_r1", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step("wrap_w2", 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) step("wrap_r2", 1'b0, 8'h00, 1'b1);

    // Simultaneous read+write while full: 0xAA must emerge last.
    for (int i = 0; i < DEPTH; i++) step("sim_fill", 1'b1, 8'(8'hB0 + i), 1'b0);
    step("sim_full", 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("sim_drn", 1'b0, 8'h00, 1'b1);
    chk("sim_drn:last", 32'(dout), 32'hAA);

    // Simultaneous read+write while empty: write taken, read rejected.
    step("emp_sim", 1'b1, 8'h55, 1'b1);
    step("emp_rd", 1'b0, 8'h00, 1'b1);
    chk("emp_rd:data", 32'(dout), 32'h55);

    // Asynchronous reset between edges at count 7.
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_all("async_rst");
    #3 reset = 1'b1;
    step("post_w", 1'b1, 8'h3C, 1'b0);
    step("post_r", 1'b0, 8'h00, 1'b1);
    chk("post_r:data", 32'(dout), 32'h3C);

    // Random traffic with bursts biased toward filling and then draining.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      step("rand", ($urandom_range(99) < bias), 8'($urandom), ($urandom_range(99) >= bias));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO replacing the fixed 8×16 shift-register FIFO. It uses a circular buffer with read/write pointers, so no data moves on a read, and it accepts a read and a write in the same cycle. It adds an occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe and overflow/underflow error pulses. It sits between any producer/consumer pair in the same clock domain.

## Interface
- DATA_WIDTH, 8: width of din/dout.
- DEPTH, 16: number of entries; must be a power of two, ≥ 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- Derived: AW = $clog2(DEPTH); count width AW+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data, sampled when a write is accepted.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data, registered.
- dout_valid  out  1  one-cycle pulse: dout updated by an accepted read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write requested but rejected.
- underflow  out  1  one-cycle pulse: read requested but rejected.

## Operation
- Storage: DEPTH × DATA_WIDTH array. Write pointer wp and read pointer rp are AW+1 bits; the MSB is the wrap bit. Array index is ptr[AW-1:0].
- Acceptance, evaluated on pre-edge state:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok). A write to a full FIFO succeeds when a read is accepted in the same cycle.
- Write: mem[wp] ← din; wp ← wp+1.
- Read: dout ← mem[rp]; rp ← rp+1; dout_valid ← 1.
- count ← count + wr_ok − rd_ok. Simultaneous accepted read and write leaves count unchanged.
- Read+write on an empty FIFO: the write is accepted, the read is rejected, and underflow pulses. There is no fall-through.
- overflow ← wr_en & !wr_ok; underflow ← rd_en & !rd_ok.
- dout holds its value when there is no accepted read.
- The memory array is not reset. Contents are don't-care until written.
- Pointers wrap naturally modulo 2·DEPTH. full/empty come from count, or equivalently from pointer compare: same index with wrap bits differing = full, identical = empty.

## Timing
- Reset (reset=0, asynchronous assert, synchronous-safe release): wp=rp=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
- Reset mid-operation discards all stored data immediately. The first edge after release behaves as from empty.
- Write-to-read latency: data written at edge N is readable with rd_en at edge N+1 and appears on dout after that edge.
- Read latency: 1 cycle. dout and dout_valid update on the edge that accepts rd_en.
- All flags and count are registered or derived from registered count. They reflect state after the last edge and have no combinational path from wr_en or rd_en.
- overflow and underflow are high for exactly the cycle after the offending edge.

## Structure
- Shared package fifo_pkg holds:
  - a clog2 helper function, if the tool flow lacks $clog2.
  - parameter legality checks: DEPTH a power of two; AE_THRESH < AF_THRESH ≤ DEPTH.
- Sub-module fifo_ram: simple dual-port register array with one write port and a registered read port. Parameters DATA_WIDTH and DEPTH. Ports clk, we, waddr, wdata, re, raddr, rdata.
- Top level holds the pointers, count, flags and error pulses.

## Test plan
All scenarios use defaults (8-bit, DEPTH=16, AF=14, AE=2).
1. Reset then fill: write 0x01..0x10 → count steps 1..16; almost_empty drops at count 3; almost_full rises at 14; full at 16; a 17th write gives overflow=1 for one cycle with count still 16.
2. Drain: 16 reads after (1) → dout 0x01..0x10 in order, each with dout_valid; empty=1 afterwards; one further read gives underflow=1 and dout stays 0x10.
3. Wrap-around: 10 writes, 10 reads, then 12 writes and 12 reads → data in order across the index wrap; count returns to 0.
4. Simultaneous access: at count=16, assert wr_en+rd_en with din=0xAA → no overflow, count stays 16, dout = oldest entry; 0xAA emerges last on drain.
5. Empty simultaneous access: at count=0, assert wr_en+rd_en with din=0x55 → count=1, underflow=1, dout_valid=0; next read returns 0x55.
6. Async reset: assert reset=0 mid-burst at count=7, between clock edges → count=0, empty=1, dout=0 immediately; after release, a write of 0x3C then a read returns 0x3C.
